// File: rtl/insn_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder (and the decode side).
//   - fmt_e       : instruction format codes carried on fmt_i (6,7 are illegal)
//   - OPC_*       : base RV32I major opcodes
//   - *_LSB       : bit positions of the fixed register/funct fields
//   - IMM_BITS_*  : signed immediate widths per format for range checking
//   - sext_mismatch() : true when a 32-bit value is not the sign extension
//                       of its low nbits bits
package insn_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  localparam int unsigned IMM_BITS_IS = 12;
  localparam int unsigned IMM_BITS_B  = 13;
  localparam int unsigned IMM_BITS_J  = 21;

  // Bits [31:nbits-1] must all agree for imm to equal sext(imm[nbits-1:0]).
  function automatic logic sext_mismatch(input logic [31:0] imm,
                                         input int unsigned nbits);
    logic [31:0] upper;
    upper = 32'hFFFF_FFFF << (nbits - 1);
    return ((imm & upper) != 32'h0) && ((imm & upper) != upper);
  endfunction

endpackage

// File: rtl/insn_encoder_fifo.sv
// insn_fifo: small first-word-fall-through FIFO holding {err, insn} words.
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous active-high reset (pointers/count cleared)
//   push_i  in   write data_i when not full
//   pop_i   in   drop head when not empty
//   data_i  in   W-bit entry to write
//   ready_o out  not full (count < DEPTH)
//   valid_o out  not empty
//   data_o  out  head entry (meaningful only while valid_o)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module insn_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign ready_o = (count_q != FULL_CNT);
  assign valid_o = (count_q != '0);
  // A full FIFO refuses the push even when the head pops in the same cycle.
  assign push_ok = push_i & ready_o;
  assign pop_ok  = pop_i & valid_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the top gates the head with valid_o.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: packs format/opcode/register fields and a 32-bit immediate
// into one RV32I instruction word, range-checks the immediate, and buffers
// {err, insn} in a small FIFO behind valid/ready handshakes.
//   clk_i, rst_i            clock (rising) / asynchronous active-high reset
//   in_valid_i, in_ready_o  request handshake (accept = valid & ready)
//   fmt_i                   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i  request fields
//   out_valid_o, out_ready_i  result handshake (pop = valid & ready)
//   insn_o, err_o           head word and its error flag (0 while empty)
//   err_cnt_o               saturating count of accepted requests with err
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           fmt_i,
  input  logic [6:0]           opcode_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic [31:0]          imm_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          insn_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  fmt_e        fmt;
  logic [31:0] f_op, f_rd, f_rs1, f_rs2, f_f3, f_f7;
  logic [31:0] enc_insn;
  logic        enc_err;
  logic        accept;
  logic [32:0] head;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign fmt = fmt_e'(fmt_i);

  // Fixed fields pre-positioned so each format is just an OR of its parts.
  assign f_op  = {25'b0, opcode_i[6:2], 2'b11};
  assign f_rd  = 32'(rd_i)     << RD_LSB;
  assign f_f3  = 32'(funct3_i) << F3_LSB;
  assign f_rs1 = 32'(rs1_i)    << RS1_LSB;
  assign f_rs2 = 32'(rs2_i)    << RS2_LSB;
  assign f_f7  = 32'(funct7_i) << F7_LSB;

  // On a range error the word is still packed from the low immediate bits.
  always_comb begin
    enc_insn = '0;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_insn = f_f7 | f_rs2 | f_rs1 | f_f3 | f_rd | f_op;
      end
      FMT_I: begin
        enc_insn = {imm_i[11:0], 20'b0} | f_rs1 | f_f3 | f_rd | f_op;
        enc_err  = sext_mismatch(imm_i, IMM_BITS_IS);
      end
      FMT_S: begin
        enc_insn = {imm_i[11:5], 25'b0} | f_rs2 | f_rs1 | f_f3
                 | {20'b0, imm_i[4:0], 7'b0} | f_op;
        enc_err  = sext_mismatch(imm_i, IMM_BITS_IS);
      end
      FMT_B: begin
        enc_insn = {imm_i[12], imm_i[10:5], 25'b0} | f_rs2 | f_rs1 | f_f3
                 | {20'b0, imm_i[4:1], imm_i[11], 7'b0} | f_op;
        enc_err  = sext_mismatch(imm_i, IMM_BITS_B) | imm_i[0];
      end
      FMT_U: begin
        enc_insn = {imm_i[31:12], 12'b0} | f_rd | f_op;
        enc_err  = |imm_i[11:0];
      end
      FMT_J: begin
        enc_insn = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0}
                 | f_rd | f_op;
        enc_err  = sext_mismatch(imm_i, IMM_BITS_J) | imm_i[0];
      end
      default: begin
        enc_insn = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign accept = in_valid_i & in_ready_o;

  insn_fifo #(
    .DEPTH (DEPTH),
    .W     (33)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (out_ready_i),
    .data_i  ({enc_err, enc_insn}),
    .ready_o (in_ready_o),
    .valid_o (out_valid_o),
    .data_o  (head)
  );

  // Empty FIFO presents zeros rather than stale storage.
  assign insn_o = out_valid_o ? head[31:0] : 32'h0;
  assign err_o  = out_valid_o & head[32];

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && enc_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed plus randomized bench for insn_encoder. A queue-based model holds
// the expected {err, insn} words; encodings come from field arithmetic.
module tb_insn_encoder;
  import insn_encoder_pkg::*;

  localparam int DEPTH   = 2;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  fmt = '0, f3 = '0;
  logic [6:0]  opcode = '0, f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] insn;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  logic [32:0] q[$];
  int model_cnt = 0;

  always #5 clk = ~clk;

  insn_encoder #(.DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .insn_o(insn), .err_o(err), .err_cnt_o(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder written straight from the field layout tables.
  function automatic logic [32:0] ref_encode();
    bit [31:0] w, op, vrd, vrs1, vrs2, vf3, vf7;
    bit e;
    int s;
    op   = 32'((opcode >> 2) * 4 + 3);
    vrd  = 32'(rd) * 32'd128;
    vf3  = 32'(f3) * 32'd4096;
    vrs1 = 32'(rs1) * 32'd32768;
    vrs2 = 32'(rs2) * 32'd1048576;
    vf7  = 32'(f7) * 32'd33554432;
    s    = $signed(imm);
    w = 32'h0;
    e = 1'b0;
    case (fmt)
      3'd0: w = vf7 | vrs2 | vrs1 | vf3 | vrd | op;
      3'd1: begin
        w = ((imm & 32'hFFF) << 20) | vrs1 | vf3 | vrd | op;
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | vrs2 | vrs1 | vf3 | ((imm & 32'h1F) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | vrs2 | vrs1 | vf3
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | op;
        e = (s < -4096) || (s > 4095) || ((imm & 32'h1) != 0);
      end
      3'd4: begin
        w = (imm & 32'hFFFFF000) | vrd | op;
        e = (imm % 4096) != 0;
      end
      3'd5: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | vrd | op;
        e = (s < -1048576) || (s > 1048575) || ((imm & 32'h1) != 0);
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(model_cnt));
    if (q.size() > 0) begin
      chk({tag, "_insn"}, insn, q[0][31:0]);
      chk({tag, "_err"}, 32'(err), 32'(q[0][32]));
    end
  endtask

  // Called at a falling edge with inputs already driven: applies the
  // handshake effects of the coming rising edge to the model, then checks.
  task automatic tick(input string tag);
    int sz;
    logic [32:0] w;
    sz = q.size();
    w = ref_encode();
    if (out_ready && sz > 0) void'(q.pop_front());
    if (in_valid && sz < DEPTH) begin
      q.push_back(w);
      if (w[32] && model_cnt < CNT_MAX) model_cnt++;
      $display("txn %s fmt=%0d imm=%h -> insn=%h err=%0d", tag, fmt, imm, w[31:0], w[32]);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic directed(input string tag, input logic [2:0] f, input logic [6:0] op,
                          input logic [4:0] d, input logic [31:0] im,
                          input logic [31:0] exp_insn, input logic exp_err);
    out_ready = 1'b0;
    set_req(f, op, d, 5'd0, 5'd0, 3'd0, 7'd0, im);
    chk({tag, "_no_bypass"}, 32'(out_valid), 32'd0);
    tick(tag);
    in_valid = 1'b0;
    chk({tag, "_const_insn"}, insn, exp_insn);
    chk({tag, "_const_err"}, 32'(err), 32'(exp_err));
    out_ready = 1'b1;
    tick({tag, "_pop"});
    out_ready = 1'b0;
  endtask

  initial begin
    logic [6:0] opc_list [7];
    opc_list = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH, OPC_STORE, OPC_OP_IMM, OPC_OP};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_insn", insn, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    directed("addi", 3'd1, OPC_OP_IMM, 5'd1, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    directed("beq",  3'd3, OPC_BRANCH, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    directed("lui",  3'd4, OPC_LUI,    5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    directed("i800", 3'd1, OPC_OP_IMM, 5'd1, 32'h0000_0800, 32'h8000_0093, 1'b1);
    chk("i800_err_cnt", 32'(err_cnt), 32'd1);
    directed("j3",   3'd5, OPC_JAL,    5'd0, 32'h0000_0003, 32'h0020_006F, 1'b1);
    chk("j3_err_cnt", 32'(err_cnt), 32'd2);

    // Backpressure: three offers into a 2-deep FIFO, then drain in order.
    out_ready = 1'b0;
    set_req(3'd4, OPC_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000); tick("bp_a");
    set_req(3'd4, OPC_LUI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2000); tick("bp_b");
    set_req(3'd4, OPC_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_3000); tick("bp_c_held");
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    tick("bp_c_held2");
    out_ready = 1'b1;
    tick("bp_pop_only");
    tick("bp_pop_push");
    in_valid = 1'b0;
    tick("bp_drain_c");
    tick("bp_empty");

    // Full FIFO with pop and offer in the same cycle: pop only, push next.
    out_ready = 1'b0;
    set_req(3'd0, OPC_OP, 5'd7, 5'd8, 5'd9, 3'd5, 7'h20, 32'd0); tick("full_a");
    set_req(3'd2, OPC_STORE, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_FFF0); tick("full_b");
    set_req(3'd1, OPC_OP_IMM, 5'd4, 5'd5, 5'd0, 3'd1, 7'd0, 32'd17);
    out_ready = 1'b1;
    tick("full_pop_only");
    tick("full_push_next");
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset with two entries held.
    set_req(3'd1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000); tick("mid_err");
    in_valid = 1'b0;
    chk("mid_two_entries", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    directed("resume", 3'd1, OPC_OP_IMM, 5'd1, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);

    // 300 illegal-format requests saturate the 8-bit counter.
    out_ready = 1'b1;
    set_req(3'd6, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 300; i++) begin
      fmt = (i % 2 == 0) ? 3'd6 : 3'd7;
      tick("sat");
    end
    in_valid = 1'b0;
    tick("sat_drain");
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    rst = 1'b1;
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      fmt = 3'($urandom_range(0, 7));
      opcode = ($urandom_range(0, 1) == 0) ? 7'($urandom) : opc_list[$urandom_range(0, 6)];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
